scene_sequencer: RTL and testbench
==================================

// Module: scene_sequencer
// PURPOSE
//  Demo timeline controller. Steps through a fixed scene table once per frame, choosing which
//  effect layers the VGA colour mux shows (plane, starfield, scroller, oscilloscope) and a global
//  fade level. All outputs change only on frame_start, so a layer never switches mid-frame.
//  Sits between the sync counters / audiotrack and the final colour mux, ahead of dithering.
// PARAMETERS
//  NUM_SCENES  4  entries in scene table (package), indices 0..NUM_SCENES-1
//  SCENE_W     2  width of scene_idx; must satisfy 2**SCENE_W >= NUM_SCENES
//  FADE_STEP   4  fade change per frame, 1..63
//  LOOP_SCENE  0  scene entered after the last scene
// PORTS
//  clk48        in   1        pixel/system clock
//  rst          in   1        synchronous reset, active-high
//  frame_start  in   1        1-cycle pulse at the vertical wrap (v_count -> 0)
//  beat         in   1        1-cycle pulse from audiotrack on each pattern row
//  skip         in   1        1-cycle manual advance request
//  scene_idx    out  SCENE_W  current scene
//  layer_en     out  4        {osc, scroller, starfield, plane} enables
//  fade         out  6        brightness 0..63; the colour mux scales by fade/64 before dither
//  scene_frame  out  12       frames since scene load, saturates at 4095
//  scene_start  out  1        1-cycle pulse when a new scene is loaded
// BEHAVIOUR
//  - Reset: state IDLE; scene_idx=0, layer_en=0, fade=0, scene_frame=0, scene_start=0;
//    pending skip/beat flags cleared. rst wins over any same-cycle input.
//  - All outputs registered. State/outputs update only in the cycle after a frame_start pulse;
//    between pulses everything holds except the skip/beat latches.
//  - skip latches into skip_pend (any cycle); consumed at the next frame_start, including the same
//    cycle's frame_start. Ignored (cleared) in IDLE and FADE_OUT.
//  - IDLE --frame_start--> LOAD(scene 0): layer_en=mask[0], fade=0, scene_frame=0,
//    scene_start=1, hold_cnt=0 -> FADE_IN.
//  - FADE_IN: fade <= min(fade+FADE_STEP, 63); reaching 63 -> HOLD. skip_pend -> FADE_OUT
//    from the current fade value, no step applied that frame.
//  - HOLD: hold_cnt++; when hold_cnt == dur[scene_idx]-1, or on skip_pend -> FADE_OUT.
//    dur==0 is treated as 1.
//  - FADE_OUT: fade <= (fade>FADE_STEP) ? fade-FADE_STEP : 0. When the result would be 0, load
//    the next scene in the same update: scene_idx = (idx==NUM_SCENES-1) ? LOOP_SCENE : idx+1;
//    layer_en=mask[new], fade=0, scene_frame=0, hold_cnt=0, scene_start=1 -> FADE_IN.
//  - scene_frame increments on every frame_start except the loading one; saturates at 4095.
//  - scene_start is high for exactly one clk48 cycle per load.
//  - Arithmetic: fade add uses 7 bits and clamps to 63. hold_cnt is 12 bits and compared to dur-1.
// CONFIGURATION
//  BEAT_SYNC_EN defined: on HOLD expiry, set expired; leave HOLD only at a frame_start at which
//    beat_pend is set. beat_pend latches beat, is cleared on that transition and on every load.
//    skip bypasses the wait.
//  BEAT_SYNC_EN undefined: beat is ignored; HOLD exits exactly at duration expiry.
// STRUCTURE
//  - Package scene_pkg: state enum (IDLE, FADE_IN, HOLD, FADE_OUT); LAYER_* bit positions;
//    scene_dur[NUM_SCENES] (12-bit frames); scene_mask[NUM_SCENES] (4-bit); FADE_MAX=63.
//  - One sub-module, fade_ramp: saturating up/down 6-bit counter with step input, plus zero/max
//    flags. The sequencing FSM stays in scene_sequencer.
// TESTING (FADE_STEP=4, dur={8,4,2,3}, masks={1,6,8,15}, pulses 1 cycle, frame_start every 100 cycles)
//  1. Reset, then the first frame_start -> scene_idx=0, layer_en=4'b0001, fade=0, one scene_start.
//     Fade reads 4,8..60 over the next 15 frames and 63 on the 16th; state HOLD.
//  2. Continue -> 8 frames after HOLD entry FADE_OUT begins: 59,55..3, then 0 with scene_idx=1,
//     layer_en=4'b0110, scene_start=1.
//  3. Run to scene 3 end -> scene_idx wraps to LOOP_SCENE=0, layer_en=4'b0001, scene_frame=0.
//  4. skip in the same cycle as frame_start during FADE_IN at fade=20 -> next fade 16, state FADE_OUT.
//     A second skip during FADE_OUT has no effect.
//  5. Assert rst mid-HOLD in scene 2 while a skip is pending -> all outputs 0, IDLE.
//     The next frame_start reloads scene 0.
//  6. BEAT_SYNC_EN, no beat after expiry -> stays HOLD with fade=63 for 10 frames.
//     beat at frame 10 -> FADE_OUT at the following frame_start.

Source files
------------

// File: rtl/scene_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// scene_pkg
//   Shared types and constants for the demo scene sequencer:
//     - seq_state_e : sequencer FSM states (IDLE, FADE_IN, HOLD, FADE_OUT)
//     - LAYER_*     : bit positions inside layer_en
//     - scene_dur   : per-scene hold time in frames (12 bits, 0 acts as 1)
//     - scene_mask  : per-scene layer enable mask
//     - FADE_MAX    : full brightness
//   No ports (package).
// -----------------------------------------------------------------------------
package scene_pkg;

    localparam int NUM_SCENES = 4;
    localparam int SCENE_W    = 2;

    localparam logic [5:0] FADE_MAX = 6'd63;

    localparam int LAYER_PLANE     = 0;
    localparam int LAYER_STARFIELD = 1;
    localparam int LAYER_SCROLLER  = 2;
    localparam int LAYER_OSC       = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        HOLD     = 2'd2,
        FADE_OUT = 2'd3
    } seq_state_e;

    localparam logic [11:0] scene_dur [NUM_SCENES] = '{12'd8, 12'd4, 12'd2, 12'd3};

    // {osc, scroller, starfield, plane}
    localparam logic [3:0] scene_mask [NUM_SCENES] = '{4'b0001, 4'b0110, 4'b1000, 4'b1111};

endpackage

// File: rtl/scene_sequencer_if.sv
// -----------------------------------------------------------------------------
// scene_sequencer_if
//   Bundles the sequencer's event inputs and timeline outputs.
//   All inputs are single-cycle pulses; there is no back-pressure, so no
//   valid/ready pairing applies: a pulse is taken in the cycle it is high.
//   Signals:
//     frame_start  pulse at vertical wrap
//     beat         pulse per audio pattern row
//     skip         manual advance request
//     scene_idx    current scene
//     layer_en     {osc, scroller, starfield, plane}
//     fade         brightness 0..63
//     scene_frame  frames since scene load (saturating)
//     scene_start  one-cycle pulse per scene load
//     state        current FSM state (debug visibility)
//   Modports: master drives the pulses (timing/audio side), slave is the
//   sequencer.
// -----------------------------------------------------------------------------
interface scene_sequencer_if #(
    parameter int SCENE_W = 2
);
    import scene_pkg::*;

    logic               frame_start;
    logic               beat;
    logic               skip;
    logic [SCENE_W-1:0] scene_idx;
    logic [3:0]         layer_en;
    logic [5:0]         fade;
    logic [11:0]        scene_frame;
    logic               scene_start;
    seq_state_e         state;

    modport master (
        output frame_start, beat, skip,
        input  scene_idx, layer_en, fade, scene_frame, scene_start, state
    );

    modport slave (
        input  frame_start, beat, skip,
        output scene_idx, layer_en, fade, scene_frame, scene_start, state
    );

endinterface

// File: rtl/scene_sequencer_fade_ramp.sv
// -----------------------------------------------------------------------------
// fade_ramp
//   Saturating 6-bit up/down brightness counter.
//   Ports:
//     clk48, rst  clock, synchronous active-high reset (value -> 0)
//     clear       force value to 0 (highest priority after reset)
//     up          value <= min(value + step, 63)
//     down        value <= (value > step) ? value - step : 0
//     step        amount per up/down command
//     value       current brightness
//     max_next    an up command now would land on 63
//     zero_next   a down command now would land on 0
// -----------------------------------------------------------------------------
module fade_ramp
    import scene_pkg::*;
(
    input  logic       clk48,
    input  logic       rst,
    input  logic       clear,
    input  logic       up,
    input  logic       down,
    input  logic [5:0] step,
    output logic [5:0] value,
    output logic       max_next,
    output logic       zero_next
);

    logic [6:0] up_sum;
    logic [5:0] up_val;
    logic [5:0] dn_val;

    // One extra bit on the add so the clamp sees the carry.
    always_comb begin
        up_sum    = {1'b0, value} + {1'b0, step};
        up_val    = (up_sum > {1'b0, FADE_MAX}) ? FADE_MAX : up_sum[5:0];
        dn_val    = (value > step) ? (value - step) : 6'd0;
        max_next  = (up_val == FADE_MAX);
        zero_next = (dn_val == 6'd0);
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            value <= 6'd0;
        end else if (clear) begin
            value <= 6'd0;
        end else if (up) begin
            value <= up_val;
        end else if (down) begin
            value <= dn_val;
        end
    end

endmodule

// File: rtl/scene_sequencer.sv
// -----------------------------------------------------------------------------
// scene_sequencer
//   Demo timeline controller. Walks a fixed scene table, one FSM step per
//   frame, selecting the visible effect layers and a global fade level. Every
//   output changes only on the edge that samples frame_start, so layers never
//   switch mid-frame.
//   Ports:
//     clk48  pixel/system clock
//     rst    synchronous reset, active-high
//     bus    scene_sequencer_if.slave (frame_start/beat/skip in, timeline out)
//   Optional build macro:
//     BEAT_SYNC_EN  when defined, HOLD expiry waits for a pending beat before
//                   fading out (skip still bypasses). When undefined, beat is
//                   ignored and HOLD ends exactly at expiry.
// -----------------------------------------------------------------------------
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int SCENE_W    = scene_pkg::SCENE_W,
    parameter int FADE_STEP  = 4,
    parameter int LOOP_SCENE = 0
) (
    input  logic         clk48,
    input  logic         rst,
    scene_sequencer_if.slave bus
);

    seq_state_e         state_q;
    logic [SCENE_W-1:0] idx_q;
    logic [3:0]         layer_q;
    logic [11:0]        frame_q;
    logic [11:0]        hold_q;
    logic               start_q;
    logic               skip_pend;
    logic               skip_now;
    logic [11:0]        dur_eff;
    logic               hold_done;
    logic [SCENE_W-1:0] idx_next;

    logic               ramp_clear;
    logic               ramp_up;
    logic               ramp_down;
    logic [5:0]         fade_val;
    logic               max_next;
    logic               zero_next;

`ifdef BEAT_SYNC_EN
    logic beat_pend;
    logic beat_now;
    logic expired;
    assign beat_now = beat_pend | bus.beat;
`endif

    // A skip arriving in the frame_start cycle itself counts for that frame.
    assign skip_now = skip_pend | bus.skip;

    always_comb begin
        dur_eff   = scene_dur[idx_q];
        if (dur_eff == 12'd0) begin
            dur_eff = 12'd1;
        end
        hold_done = (hold_q == dur_eff - 12'd1);
        idx_next  = (idx_q == SCENE_W'(NUM_SCENES - 1)) ? SCENE_W'(LOOP_SCENE)
                                                       : idx_q + SCENE_W'(1);
    end

    // Fade commands are issued in the same cycle the FSM consumes frame_start.
    always_comb begin
        ramp_clear = 1'b0;
        ramp_up    = 1'b0;
        ramp_down  = 1'b0;
        if (!rst && bus.frame_start) begin
            case (state_q)
                IDLE:     ramp_clear = 1'b1;
                FADE_IN:  ramp_up    = !skip_now;
                FADE_OUT: begin
                    ramp_clear = zero_next;
                    ramp_down  = !zero_next;
                end
                default:  ;
            endcase
        end
    end

    fade_ramp u_fade_ramp (
        .clk48     (clk48),
        .rst       (rst),
        .clear     (ramp_clear),
        .up        (ramp_up),
        .down      (ramp_down),
        .step      (6'(FADE_STEP)),
        .value     (fade_val),
        .max_next  (max_next),
        .zero_next (zero_next)
    );

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            layer_q   <= 4'd0;
            frame_q   <= 12'd0;
            hold_q    <= 12'd0;
            start_q   <= 1'b0;
            skip_pend <= 1'b0;
`ifdef BEAT_SYNC_EN
            beat_pend <= 1'b0;
            expired   <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;

            // Skip requests are meaningless while idle or already fading out.
            if (state_q == IDLE || state_q == FADE_OUT) begin
                skip_pend <= 1'b0;
            end else if (bus.skip) begin
                skip_pend <= 1'b1;
            end
`ifdef BEAT_SYNC_EN
            if (bus.beat) begin
                beat_pend <= 1'b1;
            end
`endif

            if (bus.frame_start) begin
                skip_pend <= 1'b0;
                if (frame_q != 12'hFFF) begin
                    frame_q <= frame_q + 12'd1;
                end

                case (state_q)
                    IDLE: begin
                        idx_q   <= '0;
                        layer_q <= scene_mask[0];
                        frame_q <= 12'd0;
                        hold_q  <= 12'd0;
                        start_q <= 1'b1;
                        state_q <= FADE_IN;
`ifdef BEAT_SYNC_EN
                        beat_pend <= 1'b0;
                        expired   <= 1'b0;
`endif
                    end

                    FADE_IN: begin
                        if (skip_now) begin
                            state_q <= FADE_OUT;
                        end else if (max_next) begin
                            state_q <= HOLD;
                        end
                    end

                    HOLD: begin
                        if (hold_q != 12'hFFF) begin
                            hold_q <= hold_q + 12'd1;
                        end
`ifdef BEAT_SYNC_EN
                        // Once expired, wait for a beat so the fade starts on the music.
                        if (skip_now) begin
                            state_q   <= FADE_OUT;
                            beat_pend <= 1'b0;
                            expired   <= 1'b0;
                        end else if ((expired || hold_done) && beat_now) begin
                            state_q   <= FADE_OUT;
                            beat_pend <= 1'b0;
                            expired   <= 1'b0;
                        end else if (hold_done) begin
                            expired   <= 1'b1;
                        end
`else
                        if (skip_now || hold_done) begin
                            state_q <= FADE_OUT;
                        end
`endif
                    end

                    FADE_OUT: begin
                        // Fading to black and loading the next scene happen together.
                        if (zero_next) begin
                            idx_q   <= idx_next;
                            layer_q <= scene_mask[idx_next];
                            frame_q <= 12'd0;
                            hold_q  <= 12'd0;
                            start_q <= 1'b1;
                            state_q <= FADE_IN;
`ifdef BEAT_SYNC_EN
                            beat_pend <= 1'b0;
                            expired   <= 1'b0;
`endif
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.scene_idx   = idx_q;
    assign bus.layer_en    = layer_q;
    assign bus.fade        = fade_val;
    assign bus.scene_frame = frame_q;
    assign bus.scene_start = start_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scene_sequencer
//   Self-checking bench for scene_sequencer (FADE_STEP=4, LOOP_SCENE=0,
//   frame_start every 100 cycles). A table of hand-derived per-frame
//   expectations is pushed into exp_q when each frame_start is driven and
//   popped when the outputs are sampled: once just after the update edge and
//   once mid-frame (outputs must hold, scene_start must be low).
//   Build with BEAT_SYNC_EN defined to exercise the beat-synchronised exit.
// -----------------------------------------------------------------------------
module tb_scene_sequencer;
    import scene_pkg::*;

    localparam int EW = 27;   // {idx2, layer4, fade6, sf12, start1, state2}

    localparam int MID_NONE = 0;
    localparam int MID_SKIP = 1;
    localparam int MID_BEAT = 2;
    localparam int MID_RST  = 3;

    typedef struct {
        int             frame;
        logic [EW-1:0]  exp;
    } vec_t;

    logic clk48 = 1'b0;
    logic rst;

    always #5 clk48 = ~clk48;

    scene_sequencer_if #(.SCENE_W(2)) bus ();

    scene_sequencer #(
        .SCENE_W    (2),
        .FADE_STEP  (4),
        .LOOP_SCENE (0)
    ) dut (
        .clk48 (clk48),
        .rst   (rst),
        .bus   (bus)
    );

    logic [EW-1:0] exp_q[$];
    vec_t          vecs[$];
    int            frame_no = 0;
    int            checks   = 0;
    int            errors   = 0;

    function automatic logic [EW-1:0] pack(input logic [1:0] idx, input logic [3:0] layer,
                                           input logic [5:0] fade, input logic [11:0] sf,
                                           input logic start, input seq_state_e st);
        return {idx, layer, fade, sf, start, 2'(st)};
    endfunction

    task automatic add(input int f, input logic [1:0] idx, input logic [3:0] layer,
                       input logic [5:0] fade, input logic [11:0] sf,
                       input logic start, input seq_state_e st);
        vec_t v;
        v.frame = f;
        v.exp   = pack(idx, layer, fade, sf, start, st);
        vecs.push_back(v);
    endtask

    task automatic check(input string name);
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        e = exp_q.pop_front();
        a = pack(bus.scene_idx, bus.layer_en, bus.fade, bus.scene_frame,
                 bus.scene_start, bus.state);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s frame=%0d got idx=%0d layer=%b fade=%0d sf=%0d start=%b st=%0d expected idx=%0d layer=%b fade=%0d sf=%0d start=%b st=%0d",
                     name, frame_no, a[26:25], a[24:21], a[20:15], a[14:3], a[2], a[1:0],
                     e[26:25], e[24:21], e[20:15], e[14:3], e[2], e[1:0]);
        end
    endtask

    // One frame: frame_start pulse (optionally with skip), checks, optional
    // mid-frame event, roughly 100 cycles in total.
    task automatic do_frame(input bit skip_same, input int mid);
        logic [EW-1:0] e;
        bit            has;
        has = 1'b0;
        e   = '0;
        @(negedge clk48);
        bus.frame_start = 1'b1;
        bus.skip        = skip_same;
        @(posedge clk48);
        #1;
        bus.frame_start = 1'b0;
        bus.skip        = 1'b0;
        frame_no++;
        foreach (vecs[i]) begin
            if (vecs[i].frame == frame_no) begin
                has = 1'b1;
                e   = vecs[i].exp;
            end
        end
        if (has) begin
            exp_q.push_back(e);
            check("post_edge");
        end
        repeat (30) @(posedge clk48);
        #1;
        if (has) begin
            e[2] = 1'b0;
            exp_q.push_back(e);
            check("mid_hold");
        end
        repeat (20) @(negedge clk48);
        case (mid)
            MID_SKIP: begin
                bus.skip = 1'b1;
                @(negedge clk48);
                bus.skip = 1'b0;
            end
            MID_BEAT: begin
                bus.beat = 1'b1;
                @(negedge clk48);
                bus.beat = 1'b0;
            end
            MID_RST: begin
                bus.skip = 1'b1;
                @(negedge clk48);
                bus.skip = 1'b0;
                repeat (3) @(negedge clk48);
                rst = 1'b1;
                @(posedge clk48);
                #1;
                exp_q.push_back(pack(2'd0, 4'd0, 6'd0, 12'd0, 1'b0, IDLE));
                check("reset_mid_hold");
                @(negedge clk48);
                rst = 1'b0;
                frame_no = 0;
            end
            default: ;
        endcase
        repeat (40) @(negedge clk48);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.skip        = 1'b0;
        bus.beat        = 1'b0;
        rst             = 1'b1;

        // Shared reload of scene 0.
        add(1,   2'd0, 4'b0001, 6'd0,  12'd0,  1'b1, FADE_IN);
        add(2,   2'd0, 4'b0001, 6'd4,  12'd1,  1'b0, FADE_IN);
        add(16,  2'd0, 4'b0001, 6'd60, 12'd15, 1'b0, FADE_IN);
        add(17,  2'd0, 4'b0001, 6'd63, 12'd16, 1'b0, HOLD);
`ifdef BEAT_SYNC_EN
        add(25,  2'd0, 4'b0001, 6'd63, 12'd24, 1'b0, HOLD);
        add(30,  2'd0, 4'b0001, 6'd63, 12'd29, 1'b0, HOLD);
        add(35,  2'd0, 4'b0001, 6'd63, 12'd34, 1'b0, HOLD);
        add(36,  2'd0, 4'b0001, 6'd63, 12'd35, 1'b0, FADE_OUT);
        add(37,  2'd0, 4'b0001, 6'd59, 12'd36, 1'b0, FADE_OUT);
`else
        add(24,  2'd0, 4'b0001, 6'd63, 12'd23, 1'b0, HOLD);
        add(25,  2'd0, 4'b0001, 6'd63, 12'd24, 1'b0, FADE_OUT);
        add(26,  2'd0, 4'b0001, 6'd59, 12'd25, 1'b0, FADE_OUT);
        add(40,  2'd0, 4'b0001, 6'd3,  12'd39, 1'b0, FADE_OUT);
        add(41,  2'd1, 4'b0110, 6'd0,  12'd0,  1'b1, FADE_IN);
        add(77,  2'd2, 4'b1000, 6'd0,  12'd0,  1'b1, FADE_IN);
        add(111, 2'd3, 4'b1111, 6'd0,  12'd0,  1'b1, FADE_IN);
        add(128, 2'd3, 4'b1111, 6'd63, 12'd17, 1'b0, HOLD);
        add(129, 2'd3, 4'b1111, 6'd63, 12'd18, 1'b0, HOLD);
        add(130, 2'd3, 4'b1111, 6'd63, 12'd19, 1'b0, FADE_OUT);
        add(131, 2'd3, 4'b1111, 6'd59, 12'd20, 1'b0, FADE_OUT);
        add(145, 2'd3, 4'b1111, 6'd3,  12'd34, 1'b0, FADE_OUT);
        add(146, 2'd0, 4'b0001, 6'd0,  12'd0,  1'b1, FADE_IN);
        add(151, 2'd0, 4'b0001, 6'd20, 12'd5,  1'b0, FADE_IN);
        add(152, 2'd0, 4'b0001, 6'd20, 12'd6,  1'b0, FADE_OUT);
        add(153, 2'd0, 4'b0001, 6'd16, 12'd7,  1'b0, FADE_OUT);
        add(155, 2'd0, 4'b0001, 6'd8,  12'd9,  1'b0, FADE_OUT);
        add(156, 2'd0, 4'b0001, 6'd4,  12'd10, 1'b0, FADE_OUT);
        add(157, 2'd1, 4'b0110, 6'd0,  12'd0,  1'b1, FADE_IN);
        add(158, 2'd1, 4'b0110, 6'd4,  12'd1,  1'b0, FADE_IN);
        add(210, 2'd2, 4'b1000, 6'd63, 12'd17, 1'b0, HOLD);
`endif

        repeat (3) @(posedge clk48);
        #1;
        exp_q.push_back(pack(2'd0, 4'd0, 6'd0, 12'd0, 1'b0, IDLE));
        check("reset_state");
        @(negedge clk48);
        rst = 1'b0;
        repeat (20) @(negedge clk48);
        // Idle without frame_start: nothing may move.
        exp_q.push_back(pack(2'd0, 4'd0, 6'd0, 12'd0, 1'b0, IDLE));
        check("idle_hold");

`ifdef BEAT_SYNC_EN
        for (int f = 1; f <= 37; f++) begin
            do_frame(1'b0, (f == 35) ? MID_BEAT : MID_NONE);
        end
`else
        for (int f = 1; f <= 210; f++) begin
            int mid;
            mid = MID_NONE;
            if (f >= 115 && f <= 129) mid = MID_BEAT;   // beat must be ignored
            if (f == 154)             mid = MID_SKIP;   // skip during FADE_OUT
            if (f == 210)             mid = MID_RST;    // reset with skip pending
            do_frame(f == 152, mid);
        end
        // After the mid-HOLD reset: reload scene 0, pending skip must be gone.
        do_frame(1'b0, MID_NONE);
        do_frame(1'b0, MID_NONE);
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
